aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Upstream feeder for the AES core. Accepts a byte stream over a valid/ready handshake, assembles the first 16 bytes after reset (or after a key-load request) into the 128-bit cipher key, and packs subsequent bytes into 128-bit plaintext blocks. Each block is presented to the core with a valid/ready handshake. Byte order is big-endian: the first byte received lands in bits [127:120].

## Interface
Parameters:
- BYTES_PER_BLOCK, 16, bytes per block. Fixed for AES-128; other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- iByte  input  8  stream data.
- iByteValid  input  1  iByte is valid this cycle.
- oByteReady  output  1  packer accepts a byte this cycle.
- iLast  input  1  the current byte ends the message. Used only with padding enabled.
- iKeyLoad  input  1  one-cycle request to reload the key.
- oKey  output  128  assembled key.
- oKeyValid  output  1  oKey is complete and stable.
- oPlaintext  output  128  assembled block.
- oBlockValid  output  1  oPlaintext is valid.
- iBlockReady  input  1  core accepts the block.

## Operation
- A byte is accepted when iByteValid and oByteReady are both high at a clk edge. A block is transferred when oBlockValid and iBlockReady are both high.
- States:
  - KEY: collect key bytes.
  - COLLECT: collect plaintext bytes.
  - HOLD: block presented, waiting for the core.
- 4-bit byte counter cnt, 0..15.
- Reset: state=KEY, cnt=0, oKey=0, oKeyValid=0, oPlaintext=0, oBlockValid=0, oByteReady=1 (combinational from state), internal pad flag=0.
- oByteReady = (state==KEY) or (state==COLLECT).
- KEY:
  - Each accepted byte is shifted into oKey at byte position cnt.
  - On the 16th byte: oKeyValid<=1, cnt<=0, go to COLLECT.
  - oKeyValid stays 0 for the whole of KEY.
- COLLECT:
  - Each accepted byte is written into oPlaintext at byte position cnt.
  - On the 16th byte: oBlockValid<=1, cnt<=0, go to HOLD.
- HOLD:
  - On transfer: oBlockValid<=0, go to COLLECT.
  - With the pad flag set, behaviour is described under Configuration.
- iKeyLoad:
  - In KEY or COLLECT: oKeyValid<=0, cnt<=0, go to KEY. Any partially collected block is discarded.
  - In HOLD: ignored.
  - A byte accepted in the same cycle as iKeyLoad is discarded.
- The cnt wrap from 15 to 0 coincides with the state change. No other wrap exists.

## Timing
- If the 16th byte is accepted at edge N, oBlockValid (or oKeyValid) is high after edge N. Latency is zero cycles beyond the accepting edge.
- Transfer at edge M: oByteReady is high after edge M. Best case is one idle cycle per block, so maximum throughput is 16 bytes per 17 cycles.
- Holding iBlockReady low keeps oPlaintext and oBlockValid stable indefinitely.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous reset). Partial key and block data are lost.

## Configuration
- AES_PACK_PAD_EN defined: PKCS#7 padding is enabled.
  - iLast on an accepted COLLECT byte, with k bytes held including this one:
    - If k<16, bytes k..15 are filled with value 16-k on the same edge, oBlockValid<=1, go to HOLD.
    - If k==16, the pad flag is set. After that block transfers, oPlaintext is loaded with sixteen bytes of 0x10, oBlockValid stays high, the pad flag clears, and the state stays HOLD.
  - iLast in KEY is ignored.
- AES_PACK_PAD_EN undefined:
  - iLast is ignored.
  - A block is emitted only when 16 bytes are present.
  - The pad flag logic is absent.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_BYTES=16 and AES_KEY_BYTES=16.
  - The packer state enum (KEY, COLLECT, HOLD).
  - PKCS_FULL_PAD=8'h10.
- One sub-module is natural: aes_byte_insert, a combinational function/module that writes a byte at index cnt into a 128-bit word and, under AES_PACK_PAD_EN, pad-fills the tail.
- This block connects directly to the AES_top key and plaintext inputs.

## Test plan
- Key load: after reset, send bytes 31 32 33 34 35 36 37 38 39 30 31 32 33 34 35 36 -> oKey=128'h31323334353637383930313233343536 and oKeyValid high after the 16th accept.
- Block: send 30 39 38 37 36 35 34 33 32 31 36 35 34 33 32 31 with iBlockReady=1 -> oPlaintext=128'h30393837363534333231363534333231, oBlockValid high for exactly one cycle, oByteReady low for exactly that cycle.
- Backpressure: hold iBlockReady=0 for 10 cycles -> oByteReady stays 0, oPlaintext is stable, and the next byte is accepted only after the transfer.
- iKeyLoad after 5 plaintext bytes -> partial block discarded, oKeyValid=0, and the next 16 bytes form the new key.
- Reset: assert rst mid-key after 7 bytes -> all outputs return to 0 and the next 16 bytes form the key.
- With AES_PACK_PAD_EN:
  - iLast on the 3rd byte AA BB CC -> oPlaintext=AABBCC followed by thirteen 0D bytes.
  - iLast on the 16th byte -> the data block, then a block of sixteen 0x10 bytes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block/key sizes, packer state encoding, PKCS#7 full-pad byte.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_KEY_BYTES   = 16;

  localparam logic [7:0] PKCS_FULL_PAD = 8'h10;

  typedef enum logic [1:0] {
    KEY     = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } packState_t;

endpackage

// File: rtl/aes_byte_insert.sv
// Writes one byte at big-endian position iIdx of a 128-bit word.
// With AES_PACK_PAD_EN defined, can also PKCS#7-fill every byte after iIdx.
module aes_byte_insert
  import aes_pkg::*;
(
  input  logic [8*AES_BLOCK_BYTES-1:0] iWord,
  input  logic [7:0]                   iByte,
  input  logic [3:0]                   iIdx,
`ifdef AES_PACK_PAD_EN
  input  logic                         iPadFill,
`endif
  output logic [8*AES_BLOCK_BYTES-1:0] oWord
);

  always_comb begin
    oWord = iWord;
    for (int j = 0; j < AES_BLOCK_BYTES; j++) begin
      if (4'(j) == iIdx) begin
        oWord[8*(AES_BLOCK_BYTES-1-j) +: 8] = iByte;
      end
`ifdef AES_PACK_PAD_EN
      // Holding iIdx+1 bytes, so each pad byte carries 16-(iIdx+1).
      else if (iPadFill && (4'(j) > iIdx)) begin
        oWord[8*(AES_BLOCK_BYTES-1-j) +: 8] = {4'h0, 4'hF - iIdx};
      end
`endif
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Byte-stream to AES key / plaintext block packer (big-endian, first byte in [127:120]).
// Optional PKCS#7 padding on iLast when AES_PACK_PAD_EN is defined.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = AES_BLOCK_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   iByte,
  input  logic                         iByteValid,
  output logic                         oByteReady,
  input  logic                         iLast,
  input  logic                         iKeyLoad,
  output logic [8*BYTES_PER_BLOCK-1:0] oKey,
  output logic                         oKeyValid,
  output logic [8*BYTES_PER_BLOCK-1:0] oPlaintext,
  output logic                         oBlockValid,
  input  logic                         iBlockReady
);

  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLOCK - 1);

  packState_t                   state;
  logic [3:0]                   cnt;
  logic                         byteFire;
  logic                         lastByte;
  logic                         padLast;
  logic [8*BYTES_PER_BLOCK-1:0] insBase;
  logic [8*BYTES_PER_BLOCK-1:0] insWord;
`ifdef AES_PACK_PAD_EN
  logic                         padPending;
`else
  logic                         unusedLast;
`endif

  assign oByteReady = (state == KEY) || (state == COLLECT);
  assign byteFire   = iByteValid && oByteReady;
  assign lastByte   = (cnt == LAST_IDX);
  assign insBase    = (state == KEY) ? oKey : oPlaintext;

`ifdef AES_PACK_PAD_EN
  assign padLast = iLast && (state == COLLECT);
`else
  assign padLast    = 1'b0;
  assign unusedLast = iLast;
`endif

  aes_byte_insert uInsert (
    .iWord    (insBase),
    .iByte    (iByte),
    .iIdx     (cnt),
`ifdef AES_PACK_PAD_EN
    .iPadFill (padLast),
`endif
    .oWord    (insWord)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= KEY;
      cnt         <= '0;
      oKey        <= '0;
      oKeyValid   <= 1'b0;
      oPlaintext  <= '0;
      oBlockValid <= 1'b0;
`ifdef AES_PACK_PAD_EN
      padPending  <= 1'b0;
`endif
    end else begin
      unique case (state)
        KEY: begin
          if (iKeyLoad) begin
            cnt <= '0;
          end else if (byteFire) begin
            oKey <= insWord;
            if (lastByte) begin
              oKeyValid <= 1'b1;
              cnt       <= '0;
              state     <= COLLECT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        COLLECT: begin
          // A key reload wins over a simultaneous byte and drops the partial block.
          if (iKeyLoad) begin
            oKeyValid <= 1'b0;
            cnt       <= '0;
            state     <= KEY;
          end else if (byteFire) begin
            oPlaintext <= insWord;
            if (lastByte || padLast) begin
              oBlockValid <= 1'b1;
              cnt         <= '0;
              state       <= HOLD;
`ifdef AES_PACK_PAD_EN
              padPending  <= padLast && lastByte;
`endif
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (iBlockReady) begin
`ifdef AES_PACK_PAD_EN
            // A message ending exactly on a block boundary owes one full pad block.
            if (padPending) begin
              oPlaintext <= {AES_BLOCK_BYTES{PKCS_FULL_PAD}};
              padPending <= 1'b0;
            end else begin
              oBlockValid <= 1'b0;
              state       <= COLLECT;
            end
`else
            oBlockValid <= 1'b0;
            state       <= COLLECT;
`endif
          end
        end
        default: state <= KEY;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed + randomized bench for aes_block_packer; reference is a byte-array model.
// Build with AES_PACK_PAD_EN defined to also cover the padding paths.
module tb_aes_block_packer;

`ifdef AES_PACK_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   iByte;
  logic         iByteValid;
  logic         oByteReady;
  logic         iLast;
  logic         iKeyLoad;
  logic [127:0] oKey;
  logic         oKeyValid;
  logic [127:0] oPlaintext;
  logic         oBlockValid;
  logic         iBlockReady;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]   blk [16];
  logic [127:0] expWord;
  logic [7:0]   probe;

  aes_block_packer #(.BYTES_PER_BLOCK(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .iByte       (iByte),
    .iByteValid  (iByteValid),
    .oByteReady  (oByteReady),
    .iLast       (iLast),
    .iKeyLoad    (iKeyLoad),
    .oKey        (oKey),
    .oKeyValid   (oKeyValid),
    .oPlaintext  (oPlaintext),
    .oBlockValid (oBlockValid),
    .iBlockReady (iBlockReady)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packing: first byte of the array ends up in the top byte.
  function automatic logic [127:0] packBlk();
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[119:0], blk[i]};
    return w;
  endfunction

  function automatic void padFrom(input int k);
    for (int i = k; i < 16; i++) blk[i] = 8'(16 - k);
  endfunction

  task automatic randBlk();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    int guard = 0;
    iByte      = b;
    iByteValid = 1'b1;
    iLast      = last;
    while (!oByteReady && guard < 100) begin
      step();
      guard++;
    end
    check("byteReady", {127'b0, oByteReady}, 128'd1);
    step();
    iByteValid = 1'b0;
    iLast      = 1'b0;
    iByte      = 8'($urandom);
  endtask

  task automatic sendRange(input int lo, input int hi, input logic lastHi);
    logic l;
    for (int i = lo; i <= hi; i++) begin
      repeat ($urandom_range(0, 1)) step();
      if (i == hi) l = lastHi;
      else l = PAD_EN ? 1'b0 : 1'($urandom_range(0, 1));
      sendByte(blk[i], l);
    end
  endtask

  initial begin
    rst = 1'b1; iByte = '0; iByteValid = 1'b0; iLast = 1'b0;
    iKeyLoad = 1'b0; iBlockReady = 1'b0;
    repeat (2) step();
    check("rstKey", oKey, '0);
    check("rstKeyValid", {127'b0, oKeyValid}, 128'd0);
    check("rstPlain", oPlaintext, '0);
    check("rstBlockValid", {127'b0, oBlockValid}, 128'd0);
    check("rstReady", {127'b0, oByteReady}, 128'd1);
    rst = 1'b0;
    step();

    // Key load from the fixed vector.
    blk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
            8'h39, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    sendRange(0, 14, 1'b0);
    check("keyValidEarly", {127'b0, oKeyValid}, 128'd0);
    sendByte(blk[15], 1'b0);
    check("key", oKey, 128'h31323334353637383930313233343536);
    check("keyValid", {127'b0, oKeyValid}, 128'd1);
    check("keyNoBlock", {127'b0, oBlockValid}, 128'd0);

    // First block with the core always ready.
    iBlockReady = 1'b1;
    blk = '{8'h30, 8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33,
            8'h32, 8'h31, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
    sendRange(0, 15, 1'b0);
    check("blk1", oPlaintext, 128'h30393837363534333231363534333231);
    check("blk1Valid", {127'b0, oBlockValid}, 128'd1);
    check("blk1ReadyLow", {127'b0, oByteReady}, 128'd0);
    step();
    check("blk1ValidDrop", {127'b0, oBlockValid}, 128'd0);
    check("blk1ReadyBack", {127'b0, oByteReady}, 128'd1);

    // Backpressure: block held for 10 cycles, a pending byte and a key-load pulse must not act.
    iBlockReady = 1'b0;
    randBlk();
    sendRange(0, 15, 1'b0);
    expWord = packBlk();
    check("bpBlk", oPlaintext, expWord);
    probe = 8'($urandom);
    iByte = probe;
    iByteValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iKeyLoad = (i == 4);
      step();
      check("bpReady", {127'b0, oByteReady}, 128'd0);
      check("bpStable", oPlaintext, expWord);
      check("bpValid", {127'b0, oBlockValid}, 128'd1);
      check("bpKeyKept", {127'b0, oKeyValid}, 128'd1);
    end
    iKeyLoad = 1'b0;
    iBlockReady = 1'b1;
    step();
    check("bpXferValid", {127'b0, oBlockValid}, 128'd0);
    check("bpXferReady", {127'b0, oByteReady}, 128'd1);
    step();
    iByteValid = 1'b0;
    randBlk();
    blk[0] = probe;
    sendRange(1, 15, 1'b0);
    check("bpNextBlk", oPlaintext, packBlk());
    step();

    // Key reload after 5 plaintext bytes; the byte sent with the request is dropped.
    randBlk();
    sendRange(0, 4, 1'b0);
    iKeyLoad = 1'b1;
    iByteValid = 1'b1;
    iByte = 8'($urandom);
    step();
    iKeyLoad = 1'b0;
    iByteValid = 1'b0;
    check("klKeyValid", {127'b0, oKeyValid}, 128'd0);
    check("klReady", {127'b0, oByteReady}, 128'd1);
    randBlk();
    sendRange(0, 14, 1'b0);
    check("klKeyValidEarly", {127'b0, oKeyValid}, 128'd0);
    sendByte(blk[15], 1'b0);
    check("klKey", oKey, packBlk());
    check("klKeyValid2", {127'b0, oKeyValid}, 128'd1);
    randBlk();
    sendRange(0, 15, 1'b0);
    check("klBlk", oPlaintext, packBlk());
    step();

    // Asynchronous reset in the middle of a key.
    iKeyLoad = 1'b1;
    step();
    iKeyLoad = 1'b0;
    randBlk();
    sendRange(0, 6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arKey", oKey, '0);
    check("arKeyValid", {127'b0, oKeyValid}, 128'd0);
    check("arPlain", oPlaintext, '0);
    check("arBlockValid", {127'b0, oBlockValid}, 128'd0);
    check("arReady", {127'b0, oByteReady}, 128'd1);
    step();
    rst = 1'b0;
    step();
    randBlk();
    sendRange(0, 15, 1'b0);
    check("arNewKey", oKey, packBlk());
    check("arNewKeyValid", {127'b0, oKeyValid}, 128'd1);
    randBlk();
    sendRange(0, 15, 1'b0);
    check("arBlk", oPlaintext, packBlk());
    step();

    // Random blocks with random gaps and random core stalls.
    for (int r = 0; r < 6; r++) begin
      iBlockReady = 1'b0;
      randBlk();
      sendRange(0, 15, 1'b0);
      expWord = packBlk();
      check("rndBlk", oPlaintext, expWord);
      check("rndValid", {127'b0, oBlockValid}, 128'd1);
      repeat ($urandom_range(0, 3)) begin
        step();
        check("rndHold", oPlaintext, expWord);
      end
      iBlockReady = 1'b1;
      step();
      check("rndXfer", {127'b0, oBlockValid}, 128'd0);
    end

`ifdef AES_PACK_PAD_EN
    // iLast on the 3rd byte: 13 bytes of 0x0D.
    iBlockReady = 1'b0;
    blk[0] = 8'hAA; blk[1] = 8'hBB; blk[2] = 8'hCC;
    padFrom(3);
    sendRange(0, 1, 1'b0);
    sendByte(blk[2], 1'b1);
    check("pad3Valid", {127'b0, oBlockValid}, 128'd1);
    check("pad3Blk", oPlaintext, packBlk());
    iBlockReady = 1'b1;
    step();
    check("pad3Xfer", {127'b0, oBlockValid}, 128'd0);

    // iLast on the 16th byte: data block then a full 0x10 block.
    iBlockReady = 1'b0;
    randBlk();
    sendRange(0, 15, 1'b1);
    check("pad16Data", oPlaintext, packBlk());
    iBlockReady = 1'b1;
    step();
    padFrom(0);
    check("pad16Full", oPlaintext, packBlk());
    check("pad16FullValid", {127'b0, oBlockValid}, 128'd1);
    check("pad16FullReady", {127'b0, oByteReady}, 128'd0);
    step();
    check("pad16Xfer", {127'b0, oBlockValid}, 128'd0);
    check("pad16Ready", {127'b0, oByteReady}, 128'd1);
`else
    // Without padding iLast must not end a block early.
    iBlockReady = 1'b0;
    randBlk();
    sendRange(0, 2, 1'b1);
    check("noPadValid", {127'b0, oBlockValid}, 128'd0);
    check("noPadReady", {127'b0, oByteReady}, 128'd1);
    sendRange(3, 15, 1'b1);
    check("noPadBlk", oPlaintext, packBlk());
    check("noPadBlkValid", {127'b0, oBlockValid}, 128'd1);
    iBlockReady = 1'b1;
    step();
    check("noPadXfer", {127'b0, oBlockValid}, 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
